// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one single-ported instruction memory between the
// fetch port (0) and the loader/debug port (1); fixed 2-cycle response latency.
`timescale 1ns/1ps
module imem_arbiter #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    input  logic [31:0]       p0_addr,
    output logic              p0_ready,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_data,
    output logic              p0_rsp_err,
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_data,
    output logic              p1_rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              last_grant;
    logic              grant0, grant1;
    logic              err0, err1, req_err;
    logic              s1_valid, s1_port, s1_err, s1_we;
    logic [DATA_W-1:0] rsp_data;

    assign err0 = (p0_addr[1:0] != 2'b00) || (p0_addr[31:ADDR_W+2] != '0);
    assign err1 = (p1_addr[1:0] != 2'b00) || (p1_addr[31:ADDR_W+2] != '0);

    // On a tie the port that did not win last time gets the slot.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            grant0 = p0_valid & (~p1_valid | last_grant);
            grant1 = p1_valid & (~p0_valid | ~last_grant);
        end
    end

    assign p0_ready = grant0;
    assign p1_ready = grant1;
    assign req_err  = grant1 ? err1 : err0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            s1_valid   <= 1'b0;
            s1_port    <= 1'b0;
            s1_err     <= 1'b0;
            s1_we      <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            s1_valid <= grant0 | grant1;
            mem_we   <= grant1 & p1_we & ~err1;
            if (grant0 | grant1) begin
                mem_addr   <= grant1 ? p1_addr[ADDR_W+1:2] : p0_addr[ADDR_W+1:2];
                mem_wdata  <= p1_wdata;
                s1_port    <= grant1;
                s1_err     <= req_err;
                s1_we      <= grant1 & p1_we;
                last_grant <= grant1;
            end
        end
    end

    // Errored requests and write acks return zero instead of memory contents.
    assign rsp_data = (s1_err | s1_we) ? '0 : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rsp_valid <= 1'b0;
            p0_rsp_data  <= '0;
            p0_rsp_err   <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_data  <= '0;
            p1_rsp_err   <= 1'b0;
        end else begin
            p0_rsp_valid <= s1_valid & ~s1_port;
            p1_rsp_valid <= s1_valid & s1_port;
            if (s1_valid && !s1_port) begin
                p0_rsp_data <= rsp_data;
                p0_rsp_err  <= s1_err;
            end
            if (s1_valid && s1_port) begin
                p1_rsp_data <= rsp_data;
                p1_rsp_err  <= s1_err;
            end
        end
    end

endmodule
